// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serial sequence-detector family: FSM state encoding
// and the counter-width rule used by the bit-serial blocks.
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-position counter width for a WIDTH-bit word (WIDTH >= 2).
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register in front of the shifter: captures words on the
// valid/ready handshake and hands them to the shifter through load.
module bit_serializer_hold
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  state_e           state,
  input  logic             last_bit,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             load
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;

  // The shifter can take a word when idle or while its last bit is on the wire,
  // which is what lets consecutive words stream without a gap.
  always_comb begin
    load        = hold_full_q & ((state == ST_IDLE) | ((state == ST_SHIFT) & last_bit));
    din_ready   = ~hold_full_q | load;
    accept      = din_valid & din_ready;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign hold      = hold_q;
  assign hold_full = hold_full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence-detector FSMs: shifts WIDTH-bit words
// out one bit per clock with x_valid/frame_start framing and no gap between words.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_start_q, frame_start_d;

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             load;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  bit_serializer_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .state    (state_q),
    .last_bit (last_bit),
    .hold     (hold),
    .hold_full(hold_full),
    .load     (load)
  );

  // The shifter moves the already-sent bit out, so the next bit always sits
  // one position in from the sending end.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shifter_d     = shifter_q;
    x_d           = x_q;
    x_valid_d     = x_valid_q;
    frame_start_d = 1'b0;
    if (load) begin
      state_d       = ST_SHIFT;
      cnt_d         = '0;
      shifter_d     = hold;
      x_d           = (MSB_FIRST != 0) ? hold[WIDTH-1] : hold[0];
      x_valid_d     = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (!last_bit) begin
            cnt_d     = cnt_q + 1'b1;
            shifter_d = (MSB_FIRST != 0) ? (shifter_q << 1) : (shifter_q >> 1);
            x_d       = (MSB_FIRST != 0) ? shifter_q[WIDTH-2] : shifter_q[1];
          end else begin
            state_d   = ST_IDLE;
            x_d       = IDLE_LEVEL;
            x_valid_d = 1'b0;
          end
        end
        default: begin
          x_d       = IDLE_LEVEL;
          x_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shifter_q     <= '0;
      x_q           <= IDLE_LEVEL;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shifter_q     <= shifter_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == ST_SHIFT) | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: an MSB-first and an LSB-first instance,
// with a per-bit scoreboard filled at each accepted handshake.
module tb_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] din_a, din_b;
  logic din_valid_a, din_valid_b;
  logic din_ready_a, din_ready_b;
  logic x_a, x_b, x_valid_a, x_valid_b, fs_a, fs_b, busy_a, busy_b;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
    .x(x_a), .x_valid(x_valid_a), .frame_start(fs_a), .busy(busy_a)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
    .x(x_b), .x_valid(x_valid_b), .frame_start(fs_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {frame_start, x}
  typedef logic [1:0] exp_t;
  exp_t qa[$];
  exp_t qb[$];

  task automatic push_word(input bit sel_b, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      logic b;
      b = sel_b ? w[i] : w[W-1-i];
      if (sel_b) qb.push_back({(i == 0), b});
      else       qa.push_back({(i == 0), b});
    end
  endtask

  // Present a word until the DUT takes it; returns at the negedge after the transfer edge.
  task automatic offer(input bit sel_b, input logic [W-1:0] w);
    bit done;
    done = 1'b0;
    if (sel_b) begin din_b = w; din_valid_b = 1'b1; end
    else       begin din_a = w; din_valid_a = 1'b1; end
    for (int c = 0; c < 40 && !done; c++) begin
      if ((sel_b && din_ready_b) || (!sel_b && din_ready_a)) begin
        push_word(sel_b, w);
        done = 1'b1;
      end
      @(negedge clk);
    end
    din_valid_a = 1'b0;
    din_valid_b = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL offer_timeout word=%h got no din_ready, required transfer within 40 cycles", w);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (x_valid_a) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL mon_a_extra x=%b fs=%b but no bit expected", x_a, fs_a);
        end else begin
          exp_t e;
          e = qa.pop_front();
          if ({fs_a, x_a} !== e) begin
            errors++;
            $display("FAIL mon_a_bit x=%b fs=%b required x=%b fs=%b", x_a, fs_a, e[0], e[1]);
          end
        end
      end else begin
        checks++;
        if (x_a !== 1'b0 || fs_a !== 1'b0) begin
          errors++;
          $display("FAIL mon_a_idle x=%b fs=%b required x=0 fs=0", x_a, fs_a);
        end
      end
      if (x_valid_b) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL mon_b_extra x=%b fs=%b but no bit expected", x_b, fs_b);
        end else begin
          exp_t e;
          e = qb.pop_front();
          if ({fs_b, x_b} !== e) begin
            errors++;
            $display("FAIL mon_b_bit x=%b fs=%b required x=%b fs=%b", x_b, fs_b, e[0], e[1]);
          end
        end
      end else begin
        checks++;
        if (x_b !== 1'b0 || fs_b !== 1'b0) begin
          errors++;
          $display("FAIL mon_b_idle x=%b fs=%b required x=0 fs=0", x_b, fs_b);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    din_a = '0; din_b = '0; din_valid_a = 1'b0; din_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({x_a, x_valid_a, fs_a, busy_a, din_ready_a} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state x,xv,fs,busy,rdy=%b required 00001",
               {x_a, x_valid_a, fs_a, busy_a, din_ready_a});
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [2:0] hist;
    int det;
    hist = '0;
    det  = 0;
    offer(1'b0, 8'b0110_0011);
    checks++;
    if (x_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_gap x_valid=%b required 0", x_valid_a);
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (x_valid_a !== 1'b1 || fs_a !== (i == 0) || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL single_frame bit=%0d xv=%b fs=%b busy=%b required xv=1 fs=%b busy=1",
                 i, x_valid_a, fs_a, busy_a, (i == 0));
      end
      hist = {hist[1:0], x_a};
      if (hist == 3'b011) det++;
    end
    checks++;
    if (det != 2) begin
      errors++;
      $display("FAIL single_011_count got %0d required 2", det);
    end
    @(negedge clk);
    checks++;
    if (x_valid_a !== 1'b0 || x_a !== 1'b0 || busy_a !== 1'b0 || qa.size() != 0) begin
      errors++;
      $display("FAIL single_end xv=%b x=%b busy=%b pending=%0d required 0 0 0 0",
               x_valid_a, x_a, busy_a, qa.size());
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    int idx, vcount, first_v, last_v, nfs, fs0, fs1, low_rdy;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    idx = 0; vcount = 0; first_v = -1; last_v = -1; nfs = 0; fs0 = -1; fs1 = -1; low_rdy = 0;
    for (int c = 0; c < 25; c++) begin
      if (x_valid_a) begin
        vcount++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (fs_a) begin
        if (nfs == 0) fs0 = c; else fs1 = c;
        nfs++;
      end
      if (!din_ready_a) low_rdy++;
      if (idx < 2) begin
        din_a = words[idx];
        din_valid_a = 1'b1;
        if (din_ready_a) begin
          push_word(1'b0, words[idx]);
          idx++;
        end
      end else begin
        din_valid_a = 1'b0;
      end
      @(negedge clk);
    end
    din_valid_a = 1'b0;
    checks++;
    if (idx != 2 || vcount != 16 || (last_v - first_v) != 15) begin
      errors++;
      $display("FAIL b2b_stream accepted=%0d valid_cycles=%0d span=%0d required 2 16 15",
               idx, vcount, last_v - first_v);
    end
    checks++;
    if (nfs != 2 || (fs1 - fs0) != 8) begin
      errors++;
      $display("FAIL b2b_frame_start pulses=%0d spacing=%0d required 2 8", nfs, fs1 - fs0);
    end
    checks++;
    if (low_rdy != W - 1 || qa.size() != 0) begin
      errors++;
      $display("FAIL b2b_ready_low cycles=%0d pending=%0d required %0d 0", low_rdy, qa.size(), W - 1);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_lsb_first();
    offer(1'b1, 8'h01);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (x_valid_b !== 1'b1 || x_b !== (i == 0)) begin
        errors++;
        $display("FAIL lsb_bit bit=%0d xv=%b x=%b required xv=1 x=%b", i, x_valid_b, x_b, (i == 0));
      end
    end
    @(negedge clk);
    checks++;
    if (x_valid_b !== 1'b0 || x_b !== 1'b0 || qb.size() != 0) begin
      errors++;
      $display("FAIL lsb_end xv=%b x=%b pending=%0d required 0 0 0", x_valid_b, x_b, qb.size());
    end
    $display("test_lsb_first done");
  endtask

  task automatic test_reset_mid_word();
    int nfs, vcount, ones;
    nfs = 0; vcount = 0; ones = 0;
    offer(1'b0, 8'hC3);
    offer(1'b0, 8'h5A);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({x_a, x_valid_a, fs_a, busy_a, din_ready_a} !== 5'b00001) begin
      errors++;
      $display("FAIL async_reset x,xv,fs,busy,rdy=%b required 00001",
               {x_a, x_valid_a, fs_a, busy_a, din_ready_a});
    end
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    offer(1'b0, 8'hFF);
    for (int c = 0; c < 12; c++) begin
      if (fs_a) nfs++;
      if (x_valid_a) begin
        vcount++;
        if (x_a) ones++;
      end
      @(negedge clk);
    end
    checks++;
    if (nfs != 1 || vcount != 8 || ones != 8 || qa.size() != 0) begin
      errors++;
      $display("FAIL reset_discard fs=%0d valid=%0d ones=%0d pending=%0d required 1 8 8 0",
               nfs, vcount, ones, qa.size());
    end
    $display("test_reset_mid_word done");
  endtask

  task automatic test_full_stall();
    int stall;
    bit took;
    stall = 0;
    took  = 1'b0;
    offer(1'b0, 8'h96);
    offer(1'b0, 8'h4B);
    din_a = 8'hE1;
    din_valid_a = 1'b1;
    for (int c = 0; c < 20 && !took; c++) begin
      if (din_ready_a) begin
        checks++;
        if (x_valid_a !== 1'b1 || x_a !== 1'b0) begin
          errors++;
          $display("FAIL stall_release_point xv=%b x=%b required last bit of 8'h96 (xv=1 x=0)",
                   x_valid_a, x_a);
        end
        push_word(1'b0, 8'hE1);
        took = 1'b1;
      end else begin
        stall++;
      end
      @(negedge clk);
    end
    din_valid_a = 1'b0;
    checks++;
    if (!took || stall != W - 1) begin
      errors++;
      $display("FAIL stall_cycles took=%0d stalled=%0d required 1 %0d", took, stall, W - 1);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (qa.size() != 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain pending=%0d busy=%b required 0 0", qa.size(), busy_a);
    end
    $display("test_full_stall done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_full_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
